// File: rtl/jtag_ram_arbiter.sv
// Arbiter sharing one single-port RAM between a JTAG write buffer, a JTAG
// read-address prefetcher and a req/gnt user port, all clocked by tck.
`timescale 1ns/1ps

module jtag_ram_arbiter #(
    parameter int DR_LENGTH  = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  tck,
    input  logic                  reset_n,
    input  logic                  jtag_wr_strobe,
    input  logic [DR_LENGTH-1:0]  jtag_waddr,
    input  logic [DR_LENGTH-1:0]  jtag_wdata,
    input  logic [DR_LENGTH-1:0]  jtag_raddr,
    output logic [DR_LENGTH-1:0]  jtag_rdata,
    output logic                  jtag_rdata_valid,
    input  logic                  usr_req,
    input  logic                  usr_we,
    input  logic [ADDR_WIDTH-1:0] usr_addr,
    input  logic [DR_LENGTH-1:0]  usr_wdata,
    output logic                  usr_gnt,
    output logic                  usr_rvalid,
    output logic [DR_LENGTH-1:0]  usr_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DR_LENGTH-1:0]  ram_wdata,
    input  logic [DR_LENGTH-1:0]  ram_rdata
);

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_JW   = 2'd1,
        SLOT_JR   = 2'd2,
        SLOT_USR  = 2'd3
    } slot_e;

    slot_e                 slot_s;
    logic                  compete_s;
    logic                  jr_need_s;
    logic                  hit_fetch_s;
    logic                  discard_s;
    logic [ADDR_WIDTH-1:0] raddr_lo_s;
    logic [ADDR_WIDTH-1:0] ram_addr_s;
    logic                  ram_we_s;
    logic [DR_LENGTH-1:0]  ram_wdata_s;

    logic                  wbuf_full_r;
    logic [ADDR_WIDTH-1:0] wbuf_addr_r;
    logic [DR_LENGTH-1:0]  wbuf_data_r;
    logic [ADDR_WIDTH-1:0] fetch_addr_r;
    logic                  fetch_valid_r;
    logic                  inflight_r;
    logic [ADDR_WIDTH-1:0] inflight_addr_r;
    logic [DR_LENGTH-1:0]  jtag_rdata_r;
    logic                  last_user_r;
    logic                  usr_rd_pend_r;
    logic                  usr_rvalid_r;
    logic [DR_LENGTH-1:0]  usr_rdata_r;
    logic [ADDR_WIDTH-1:0] ram_addr_hold_r;

    // Address bits above the RAM depth are deliberately ignored (wrap-around).
    logic unused_bits_s;
    assign unused_bits_s = ^{jtag_raddr[DR_LENGTH-1:ADDR_WIDTH], jtag_waddr[DR_LENGTH-1:ADDR_WIDTH]};

    assign raddr_lo_s = jtag_raddr[ADDR_WIDTH-1:0];
    assign jr_need_s  = !inflight_r && (!fetch_valid_r || (fetch_addr_r != raddr_lo_s));

    // Slot arbitration: buffered write first, then round-robin JR vs user.
    always_comb begin
        slot_s    = SLOT_IDLE;
        compete_s = 1'b0;
        if (!reset_n) begin
            slot_s = SLOT_IDLE;
        end else if (wbuf_full_r) begin
            slot_s = SLOT_JW;
        end else if (jr_need_s && usr_req) begin
            compete_s = 1'b1;
            slot_s    = last_user_r ? SLOT_JR : SLOT_USR;
        end else if (jr_need_s) begin
            slot_s = SLOT_JR;
        end else if (usr_req) begin
            slot_s = SLOT_USR;
        end else begin
            slot_s = SLOT_IDLE;
        end
    end

    // RAM command mux; an idle slot keeps the previous address on the bus.
    always_comb begin
        ram_addr_s  = ram_addr_hold_r;
        ram_we_s    = 1'b0;
        ram_wdata_s = wbuf_data_r;
        case (slot_s)
            SLOT_JW: begin
                ram_addr_s  = wbuf_addr_r;
                ram_we_s    = 1'b1;
                ram_wdata_s = wbuf_data_r;
            end
            SLOT_JR: begin
                ram_addr_s = raddr_lo_s;
            end
            SLOT_USR: begin
                ram_addr_s  = usr_addr;
                ram_we_s    = usr_we;
                ram_wdata_s = usr_wdata;
            end
            default: begin
                ram_addr_s = ram_addr_hold_r;
            end
        endcase
    end

    // A write to the cached or in-flight address invalidates prefetched data.
    assign hit_fetch_s = ram_we_s && fetch_valid_r && (ram_addr_s == fetch_addr_r);
    assign discard_s   = ram_we_s && inflight_r && (ram_addr_s == inflight_addr_r);

    // One-entry JTAG write buffer; a new strobe wins over a same-cycle drain.
    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            wbuf_full_r <= 1'b0;
            wbuf_addr_r <= '0;
            wbuf_data_r <= '0;
        end else if (jtag_wr_strobe) begin
            wbuf_full_r <= 1'b1;
            wbuf_addr_r <= jtag_waddr[ADDR_WIDTH-1:0];
            wbuf_data_r <= jtag_wdata;
        end else if (slot_s == SLOT_JW) begin
            wbuf_full_r <= 1'b0;
        end else begin
            wbuf_full_r <= wbuf_full_r;
        end
    end

    // Prefetch tracking: returning JR data is captured unless a write raced it.
    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            inflight_r      <= 1'b0;
            inflight_addr_r <= '0;
            fetch_valid_r   <= 1'b0;
            fetch_addr_r    <= '0;
            jtag_rdata_r    <= '0;
        end else begin
            inflight_r <= (slot_s == SLOT_JR);
            if (slot_s == SLOT_JR) begin
                inflight_addr_r <= raddr_lo_s;
            end
            if (inflight_r && !discard_s) begin
                fetch_valid_r <= 1'b1;
                fetch_addr_r  <= inflight_addr_r;
                jtag_rdata_r  <= ram_rdata;
            end else if (hit_fetch_s) begin
                fetch_valid_r <= 1'b0;
            end else begin
                fetch_valid_r <= fetch_valid_r;
            end
        end
    end

    // Round-robin flag moves only when JR and user actually contend.
    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            last_user_r <= 1'b0;
        end else if (compete_s) begin
            last_user_r <= (slot_s == SLOT_USR);
        end else begin
            last_user_r <= last_user_r;
        end
    end

    // User read return pipeline: data is taken one cycle after the grant.
    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            usr_rd_pend_r <= 1'b0;
            usr_rvalid_r  <= 1'b0;
            usr_rdata_r   <= '0;
        end else begin
            usr_rd_pend_r <= (slot_s == SLOT_USR) && !usr_we;
            usr_rvalid_r  <= usr_rd_pend_r;
            if (usr_rd_pend_r) begin
                usr_rdata_r <= ram_rdata;
            end
        end
    end

    // Remember the last issued address for idle cycles.
    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr_hold_r <= '0;
        end else if (slot_s != SLOT_IDLE) begin
            ram_addr_hold_r <= ram_addr_s;
        end else begin
            ram_addr_hold_r <= ram_addr_hold_r;
        end
    end

    assign ram_addr         = ram_addr_s;
    assign ram_we           = ram_we_s;
    assign ram_wdata        = ram_wdata_s;
    assign usr_gnt          = (slot_s == SLOT_USR);
    assign usr_rvalid       = usr_rvalid_r;
    assign usr_rdata        = usr_rdata_r;
    assign jtag_rdata       = jtag_rdata_r;
    assign jtag_rdata_valid = fetch_valid_r && (fetch_addr_r == raddr_lo_s);

endmodule

// File: doc/jtag_ram_arbiter.md
# jtag_ram_arbiter

Shares one single-port, 1-cycle-latency RAM between the JTAG virtual-DR side and a local user port, all in the `tck` domain. JTAG writes (one-cycle write strobe plus address/data) are buffered and issued with top priority. The JTAG read address is continuously prefetched, so read data is already valid when the DR capture occurs. User accesses use a req/gnt handshake and share the remaining slots round-robin with JTAG prefetches.

## Interface
- `DR_LENGTH`, 32: data and address-bus width on the JTAG side.
- `ADDR_WIDTH`, 10: RAM address width. Only the low `ADDR_WIDTH` bits of any address are used.

Ports:
- `tck`  in  1  clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `jtag_wr_strobe`  in  1  one-cycle JTAG write request
- `jtag_waddr`  in  DR_LENGTH  JTAG write address, sampled with the strobe
- `jtag_wdata`  in  DR_LENGTH  JTAG write data, sampled with the strobe
- `jtag_raddr`  in  DR_LENGTH  JTAG read address, level, may change at any edge
- `jtag_rdata`  out  DR_LENGTH  prefetched data for `jtag_raddr`
- `jtag_rdata_valid`  out  1  `jtag_rdata` matches the current `jtag_raddr` and is coherent
- `usr_req`  in  1  user request, held until granted
- `usr_we`  in  1  1 = write, 0 = read
- `usr_addr`  in  ADDR_WIDTH  user address
- `usr_wdata`  in  DR_LENGTH  user write data
- `usr_gnt`  out  1  combinational; the request is issued on this edge
- `usr_rvalid`  out  1  one-cycle pulse; `usr_rdata` is valid
- `usr_rdata`  out  DR_LENGTH  user read data
- `ram_addr`  out  ADDR_WIDTH  combinational RAM address
- `ram_we`  out  1  combinational RAM write enable
- `ram_wdata`  out  DR_LENGTH  combinational RAM write data
- `ram_rdata`  in  DR_LENGTH  RAM read data, valid the cycle after address issue

## Operation
- One RAM slot per cycle. Slot owners: JW (buffered JTAG write), JR (JTAG prefetch read), U (user request).
- **Write buffer:** a one-entry holding register.
  - Loaded on the edge where `jtag_wr_strobe` = 1.
  - Drained by a JW slot.
  - A strobe that arrives while JW is issuing the same cycle is accepted; there is no loss.
  - A strobe that arrives while the buffer is full and not draining overwrites the entry. This cannot occur, because JW has top priority.
- **Prefetch state:** `fetch_addr`, `fetch_valid`, and `inflight` (JR issued, data returning next cycle).
  - JR is needed when no JR is in flight and either `fetch_valid` = 0 or `fetch_addr` ≠ `jtag_raddr[ADDR_WIDTH-1:0]`.
- **Arbitration each cycle:**
  1. JW, if the buffer is full.
  2. Otherwise, between JR-needed and `usr_req`: round-robin, driven by the flag `last_user`. If `last_user` = 1, JR wins; if 0, U wins. The flag updates only when both compete.
  3. A single requester always wins.
- **Coherence:**
  - Any write (JW or U) whose address equals `fetch_addr`, or the address of an in-flight JR, clears `fetch_valid`. It also sets a discard flag, so the returning JR data is dropped.
  - A refetch follows at the next free slot.
- `jtag_rdata_valid` = `fetch_valid` && (`fetch_addr` == `jtag_raddr[ADDR_WIDTH-1:0]`), combinational.
- Upper address bits above `ADDR_WIDTH` are ignored. Addresses wrap modulo 2^ADDR_WIDTH.
- Idle cycle: `ram_we` = 0 and `ram_addr` holds the last value.

## Timing
- **Reset (async assert, sync release):**
  - Write buffer empty, `fetch_valid` = 0, `inflight` = 0, `last_user` = 0.
  - `jtag_rdata` = 0, `jtag_rdata_valid` = 0, `usr_rvalid` = 0, `usr_rdata` = 0.
  - `ram_we` = 0, `ram_addr` = 0.
- Reset mid-operation: the buffered write and in-flight reads are discarded.
- **JTAG write:** strobe at edge N → `ram_we` high in cycle N..N+1 → RAM written at edge N+1.
- **JTAG prefetch:**
  - JR issued at edge N.
  - `jtag_rdata` loaded and `fetch_valid` set at edge N+1.
  - With no contention, valid rises 2 edges after `jtag_raddr` changes.
- **User read:** grant at edge N → `usr_rdata` loaded at edge N+1 → `usr_rvalid` high for one cycle after edge N+1.
- **User write:** completes at the grant edge. There is no `usr_rvalid`.
- **Worst-case user wait:** 2 slots plus any pending JW. JW arrives at most once per JTAG DR shift.
- Back-to-back user grants with no JR pending are allowed: one per cycle, `usr_rvalid` pipelined.

## Test plan
- **Reset, then idle with `jtag_raddr` = 5:**
  - JR issues `ram_addr` = 5.
  - `jtag_rdata_valid` rises 2 edges after reset release, with `jtag_rdata` = RAM[5].
- **JTAG write:** strobe with waddr = 0x10, wdata = 0xDEADBEEF while `usr_req` is held → JW issues first and the user is granted the cycle after. A later user read of 0x10 returns 0xDEADBEEF with `usr_rvalid` 2 edges after the grant.
- **Coherence:** prefetch addr 7 valid, then JTAG write to 7 with 0x1234 → `jtag_rdata_valid` drops the next edge, then refetch gives `jtag_rdata` = 0x1234. Repeat with the write landing while the JR is in flight → the stale data is discarded.
- **Contention:** continuous `usr_req` reads while `jtag_raddr` increments every cycle → grants alternate U/JR and neither starves over 20 cycles.
- **Wrap-around:** `jtag_raddr` = 0x400 with `ADDR_WIDTH` = 10 → `ram_addr` = 0 and valid reflects RAM[0].
- **Reset mid-operation:** assert `reset_n` low with a buffered write and an in-flight read → no RAM write occurs and all outputs return to reset values immediately.
